// File: rtl/ex_muldiv_pkg.sv
// Shared CPU constants for the EX-stage multiply/divide unit: opcodes, func codes, FSM encoding.
package ex_muldiv_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_MFHI  = 6'h10;
   localparam logic [5:0] FN_MTHI  = 6'h11;
   localparam logic [5:0] FN_MFLO  = 6'h12;
   localparam logic [5:0] FN_MTLO  = 6'h13;
   localparam logic [5:0] FN_MULT  = 6'h18;
   localparam logic [5:0] FN_MULTU = 6'h19;
   localparam logic [5:0] FN_DIV   = 6'h1A;
   localparam logic [5:0] FN_DIVU  = 6'h1B;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_FIX  = 2'd3
   } md_state_e;

endpackage

// File: rtl/ex_muldiv_div_iter.sv
// Iterative restoring divider on unsigned magnitudes, one quotient bit per enabled cycle.
// Only instantiated when EX_MULDIV_DIV_EN is defined.
module muldiv_div_iter (
   input  logic        clk,
   input  logic        i_reset,
   input  logic        i_step,
   input  logic        i_load,
   input  logic        i_run,
   input  logic [31:0] i_dividend,
   input  logic [31:0] i_divisor,
   output logic [31:0] o_quot,
   output logic [31:0] o_rem
);

   logic [31:0] quot_q, rem_q, dvsr_q;
   logic [32:0] trial;

   // bit 32 is the borrow; a zero divisor never borrows, giving all-ones quotient
   assign trial = {rem_q, quot_q[31]} - {1'b0, dvsr_q};

   always_ff @(posedge clk) begin
      if (i_reset) begin
         quot_q <= '0;
         rem_q  <= '0;
         dvsr_q <= '0;
      end else if (!i_step) begin
         if (i_load) begin
            quot_q <= i_dividend;
            rem_q  <= '0;
            dvsr_q <= i_divisor;
         end else if (i_run) begin
            if (!trial[32]) begin
               rem_q  <= trial[31:0];
               quot_q <= {quot_q[30:0], 1'b1};
            end else begin
               rem_q  <= {rem_q[30:0], quot_q[31]};
               quot_q <= {quot_q[30:0], 1'b0};
            end
         end
      end
   end

   assign o_quot = quot_q;
   assign o_rem  = rem_q;

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage HI/LO unit: 32-cycle shift-add multiplier, optional restoring divider (EX_MULDIV_DIV_EN),
// MTHI/MTLO writes. States: IDLE accept | MUL/DIV iterate 32x | FIX apply signs, write HI/LO.
module ex_muldiv
   import ex_muldiv_pkg::*;
(
   input  logic        clk,
   input  logic        i_reset,
   input  logic        i_step,
   input  logic        i_valid,
   input  logic [5:0]  i_opcode,
   input  logic [5:0]  i_func,
   input  logic [31:0] i_reg_DA,
   input  logic [31:0] i_reg_DB,
   output logic [31:0] o_hi,
   output logic [31:0] o_lo,
   output logic        o_busy,
   output logic        o_done
);

   md_state_e   state_q;
   logic [4:0]  cnt_q;
   logic [31:0] hi_q, lo_q, mcand_q;
   logic [63:0] prod_q;
   logic        neg_q, neg_rem_q, is_div_q, done_q;

   logic        idle_ok, sel_mul, sel_div, signed_op, a_neg, b_neg;
   logic [31:0] abs_a, abs_b;
   logic [32:0] mul_sum;
   logic [63:0] prod_fix;
   logic [31:0] div_quot, div_rem, quot_fix, rem_fix;

   assign idle_ok = (state_q == ST_IDLE) && i_valid && !i_step && (i_opcode == OP_RTYPE);
   assign sel_mul = idle_ok && ((i_func == FN_MULT) || (i_func == FN_MULTU));

`ifdef EX_MULDIV_DIV_EN
   assign sel_div = idle_ok && ((i_func == FN_DIV) || (i_func == FN_DIVU));

   muldiv_div_iter u_div (
      .clk        (clk),
      .i_reset    (i_reset),
      .i_step     (i_step),
      .i_load     (sel_div),
      .i_run      (state_q == ST_DIV),
      .i_dividend (abs_a),
      .i_divisor  (abs_b),
      .o_quot     (div_quot),
      .o_rem      (div_rem)
   );
`else
   assign sel_div  = 1'b0;
   assign div_quot = '0;
   assign div_rem  = '0;
`endif

   assign signed_op = (i_func == FN_MULT) || (i_func == FN_DIV);
   assign a_neg     = signed_op & i_reg_DA[31];
   assign b_neg     = signed_op & i_reg_DB[31];
   assign abs_a     = a_neg ? -i_reg_DA : i_reg_DA;
   assign abs_b     = b_neg ? -i_reg_DB : i_reg_DB;

   // prod_q holds {partial upper, remaining multiplier bits}; shifts right each iteration
   assign mul_sum  = {1'b0, prod_q[63:32]} + (prod_q[0] ? {1'b0, mcand_q} : 33'd0);
   assign prod_fix = neg_q ? -prod_q : prod_q;
   assign quot_fix = neg_q ? -div_quot : div_quot;
   assign rem_fix  = neg_rem_q ? -div_rem : div_rem;

   always_ff @(posedge clk) begin
      if (i_reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         mcand_q   <= '0;
         prod_q    <= '0;
         neg_q     <= 1'b0;
         neg_rem_q <= 1'b0;
         is_div_q  <= 1'b0;
         done_q    <= 1'b0;
      end else if (!i_step) begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (sel_mul) begin
                  state_q   <= ST_MUL;
                  cnt_q     <= 5'd31;
                  mcand_q   <= abs_b;
                  prod_q    <= {32'd0, abs_a};
                  neg_q     <= a_neg ^ b_neg;
                  neg_rem_q <= 1'b0;
                  is_div_q  <= 1'b0;
               end else if (sel_div) begin
                  state_q   <= ST_DIV;
                  cnt_q     <= 5'd31;
                  neg_q     <= a_neg ^ b_neg;
                  neg_rem_q <= a_neg;
                  is_div_q  <= 1'b1;
               end else if (idle_ok && (i_func == FN_MTHI)) begin
                  hi_q <= i_reg_DA;
               end else if (idle_ok && (i_func == FN_MTLO)) begin
                  lo_q <= i_reg_DA;
               end
            end
            ST_MUL: begin
               prod_q <= {mul_sum, prod_q[31:1]};
               if (cnt_q == 5'd0) state_q <= ST_FIX;
               else               cnt_q   <= cnt_q - 5'd1;
            end
            ST_DIV: begin
               if (cnt_q == 5'd0) state_q <= ST_FIX;
               else               cnt_q   <= cnt_q - 5'd1;
            end
            ST_FIX: begin
               if (is_div_q) begin
                  hi_q <= rem_fix;
                  lo_q <= quot_fix;
               end else begin
                  hi_q <= prod_fix[63:32];
                  lo_q <= prod_fix[31:0];
               end
               done_q  <= 1'b1;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign o_hi   = hi_q;
   assign o_lo   = lo_q;
   assign o_busy = (state_q != ST_IDLE);
   assign o_done = done_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: directed ops push expected {HI,LO}; a monitor checks on o_done.
module tb_ex_muldiv;
   import ex_muldiv_pkg::*;

   logic        clk = 1'b0;
   logic        i_reset, i_step, i_valid;
   logic [5:0]  i_opcode, i_func;
   logic [31:0] i_reg_DA, i_reg_DB;
   logic [31:0] o_hi, o_lo;
   logic        o_busy, o_done;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [63:0] sb_q[$];
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;

   always #5 clk = ~clk;

   ex_muldiv dut (
      .clk      (clk),
      .i_reset  (i_reset),
      .i_step   (i_step),
      .i_valid  (i_valid),
      .i_opcode (i_opcode),
      .i_func   (i_func),
      .i_reg_DA (i_reg_DA),
      .i_reg_DB (i_reg_DB),
      .o_hi     (o_hi),
      .o_lo     (o_lo),
      .o_busy   (o_busy),
      .o_done   (o_done)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin : monitor
      logic [63:0] e;
      if (o_done === 1'b1) begin
         if (sb_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_done: o_done=1 with no pending result (t=%0t)", $time);
         end else begin
            e = sb_q.pop_front();
            chk("result_hi", o_hi, e[63:32]);
            chk("result_lo", o_lo, e[31:0]);
         end
      end
   end

   // Issue one op and step through its latency, checking busy/done each cycle.
   task automatic do_op(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el,
                        input bit stall, input bit intrude);
      int lat;
      lat = stall ? 39 : 34;
      sb_q.push_back({eh, el});
      @(negedge clk);
      i_valid = 1'b1; i_opcode = OP_RTYPE; i_func = fn; i_reg_DA = a; i_reg_DB = b;
      for (int k = 1; k <= lat; k++) begin
         @(negedge clk);
         chk($sformatf("busy_c%0d", k), {31'd0, o_busy}, {31'd0, k < lat});
         chk($sformatf("done_c%0d", k), {31'd0, o_done}, {31'd0, k == lat});
         if (k == lat - 1) begin
            chk("old_hi_kept", o_hi, m_hi);
            chk("old_lo_kept", o_lo, m_lo);
         end
         if (k == 1) i_valid = 1'b0;
         if (intrude && k == 4) begin
            i_valid = 1'b1; i_func = FN_MULT; i_reg_DA = 32'd5; i_reg_DB = 32'd5;
         end
         if (intrude && k == 5) i_valid = 1'b0;
         if (stall && k == 10) i_step = 1'b1;
         if (stall && k == 15) i_step = 1'b0;
      end
      m_hi = eh;
      m_lo = el;
   endtask

   task automatic do_mt(input logic [5:0] fn, input logic [31:0] v);
      @(negedge clk);
      i_valid = 1'b1; i_opcode = OP_RTYPE; i_func = fn; i_reg_DA = v; i_reg_DB = 32'hDEAD_BEEF;
      @(negedge clk);
      i_valid = 1'b0;
      if (fn == FN_MTHI) m_hi = v;
      else               m_lo = v;
      chk("mt_hi", o_hi, m_hi);
      chk("mt_lo", o_lo, m_lo);
      chk("mt_busy", {31'd0, o_busy}, 32'd0);
   endtask

   initial begin
      i_reset = 1'b1; i_step = 1'b0; i_valid = 1'b0;
      i_opcode = '0; i_func = '0; i_reg_DA = '0; i_reg_DB = '0;
      repeat (3) @(negedge clk);
      i_reset = 1'b0;
      chk("rst_hi", o_hi, 32'd0);
      chk("rst_lo", o_lo, 32'd0);
      chk("rst_busy", {31'd0, o_busy}, 32'd0);
      chk("rst_done", {31'd0, o_done}, 32'd0);

      do_mt(FN_MTHI, 32'h0000_1234);
      do_mt(FN_MTLO, 32'h0000_5678);

      do_op(FN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0, 0);
      do_op(FN_MULT,  32'hFFFF_FFF9, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 0, 0);
      do_op(FN_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 0, 0);
      do_op(FN_MULT,  32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001, 0, 0);
      do_op(FN_MULTU, 32'd6,         32'd7,         32'd0,         32'd42,        0, 1);

`ifdef EX_MULDIV_DIV_EN
      do_op(FN_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 0);
      do_op(FN_DIVU, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF, 0, 0);
      do_op(FN_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 0, 0);
      do_op(FN_DIV,  32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'h0000_0001, 0, 0);
      do_op(FN_DIV,  32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 0, 0);
      do_op(FN_DIVU, 32'd10,        32'd3,         32'd1,         32'd3,         0, 0);
      do_op(FN_DIV,  32'd100,       32'd7,         32'd2,         32'd14,        1, 0);
`else
      @(negedge clk);
      i_valid = 1'b1; i_opcode = OP_RTYPE; i_func = FN_DIVU; i_reg_DA = 32'd10; i_reg_DB = 32'd3;
      @(negedge clk);
      i_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk("nodiv_busy", {31'd0, o_busy}, 32'd0);
         chk("nodiv_hi", o_hi, m_hi);
         chk("nodiv_lo", o_lo, m_lo);
         @(negedge clk);
      end
      do_op(FN_MULTU, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0, 1, 0);
`endif

      // reset in C10 of a MULT aborts it with no done pulse
      @(negedge clk);
      i_valid = 1'b1; i_opcode = OP_RTYPE; i_func = FN_MULT; i_reg_DA = 32'd9; i_reg_DB = 32'd9;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (k == 1) i_valid = 1'b0;
      end
      i_reset = 1'b1;
      @(negedge clk);
      i_reset = 1'b0;
      m_hi = '0;
      m_lo = '0;
      chk("abort_hi", o_hi, 32'd0);
      chk("abort_lo", o_lo, 32'd0);
      chk("abort_busy", {31'd0, o_busy}, 32'd0);
      chk("abort_done", {31'd0, o_done}, 32'd0);
      repeat (40) @(negedge clk);
      chk("abort_idle", {31'd0, o_busy}, 32'd0);

      repeat (3) @(negedge clk);
      chk("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock for all state.
REQ-002 SHALL have: i_reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have: i_step  in  1  debug freeze; 1 = every register holds its value.
REQ-004 SHALL have: i_valid  in  1  EX-stage instruction is valid and not a stall bubble.
REQ-005 SHALL have: i_opcode  in  6  and  i_func  in  6  decoded instruction fields from the ID/EX register.
REQ-006 SHALL have: i_reg_DA  in  32  (rs operand) and  i_reg_DB  in  32  (rt operand).
REQ-007 SHALL have: o_hi  out  32  and  o_lo  out  32  architectural HI/LO registers, feeding MFHI/MFLO.
REQ-008 SHALL have: o_busy  out  1  stall request to the hazard unit; driven only from registered state.
REQ-009 SHALL have: o_done  out  1  one-cycle completion pulse.

Function
REQ-010 SHALL accept an operation when state is IDLE, i_valid=1, i_step=0, i_opcode=0, and i_func is MULT 0x18, MULTU 0x19, DIV 0x1A, or DIVU 0x1B; operands are latched on that edge.
REQ-011 SHALL write o_hi from i_reg_DA (MTHI 0x11) or o_lo from i_reg_DA (MTLO 0x13) in a single cycle in IDLE; o_busy stays 0 and o_done is not pulsed.
REQ-012 SHALL implement FSM states IDLE, MUL, DIV, FIX: IDLE->MUL or IDLE->DIV on accept; MUL/DIV->FIX after exactly 32 iterations (5-bit counter); FIX->IDLE unconditionally.
REQ-013 SHALL define timing from acceptance cycle C0: o_busy=1 in C1..C33; in C34 state=IDLE, o_busy=0, o_done=1, and o_hi/o_lo hold the new result.
REQ-014 SHALL multiply by shift-add, one bit per cycle; {HI,LO} = full 64-bit product; MULT is signed, MULTU unsigned.
REQ-015 SHALL divide by restoring division, one bit per cycle; LO = quotient, HI = remainder; DIV is signed with truncation toward zero and remainder sign equal to dividend sign.
REQ-016 SHALL run signed ops on magnitudes and apply result signs in FIX.
REQ-017 SHALL produce, on divide by zero: DIVU gives LO=0xFFFFFFFF, HI=dividend; DIV gives LO=0xFFFFFFFF (dividend >=0) or 0x00000001 (dividend <0), HI=dividend. Full latency is kept.
REQ-018 SHALL produce, for DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
REQ-019 SHALL ignore i_valid/opcode inputs while state is not IDLE; upstream is held by o_busy.
REQ-020 SHALL leave o_hi/o_lo unchanged until FIX, so old values stay readable during C1..C33.
REQ-021 SHALL freeze the FSM, counter, partial results, o_hi, o_lo and o_done while i_step=1, so a pending o_done pulse is kept, not lost.

Reset
REQ-022 SHALL on i_reset=1 (priority over i_step) set state=IDLE, counter=0, o_hi=0, o_lo=0, o_busy=0, o_done=0, and clear operand/partial registers.
REQ-023 SHALL abort any operation in progress on reset; no o_done pulse follows.

Configuration
REQ-024 SHALL compile the divider only when macro EX_MULDIV_DIV_EN is defined.
REQ-025 SHALL, without EX_MULDIV_DIV_EN, treat DIV/DIVU as no-ops: no accept, no busy, HI/LO unchanged, state DIV unreachable; MULT/MULTU/MTHI/MTLO are unaffected.

Structure
REQ-026 SHALL take the func codes (0x10-0x13, 0x18-0x1B), the R-type opcode 0x00 and the FSM state encoding from the shared CPU package, alongside the ID/EX opcode constants.
REQ-027 SHALL place the iterative restoring divider in sub-module muldiv_div_iter, instantiated only under EX_MULDIV_DIV_EN; the multiplier stays inline.

Verification
REQ-028 SHALL cover: MULTU 0xFFFFFFFF x 0xFFFFFFFF -> C34: HI=0xFFFFFFFE, LO=0x00000001, o_done=1, o_busy high exactly C1..C33.
REQ-029 SHALL cover: MULT -7 x 3 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-030 SHALL cover: DIVU 100 / 0 -> LO=0xFFFFFFFF, HI=100; DIV 0x80000000 / -1 -> LO=0x80000000, HI=0.
REQ-031 SHALL cover: MTHI 0x1234 then MTLO 0x5678 -> o_hi=0x1234, o_lo=0x5678 one cycle each, o_busy never asserted.
REQ-032 SHALL cover: i_reset=1 at C10 of a MULT -> C11: o_hi=o_lo=0, o_busy=0, no o_done; i_step=1 held 5 cycles mid-DIV -> o_done moves from C34 to C39.
REQ-033 SHALL cover: a second MULT presented in C5 while busy -> ignored; with EX_MULDIV_DIV_EN undefined, DIVU 10 / 3 -> HI/LO unchanged, o_busy=0.
